debug_io_ctrl: RTL and testbench

Parametrised memory-mapped debug I/O block on the 16-bit CPU data bus: drives LEDs and the seven-segment display word, and presents synchronised, debounced switches and buttons. Unlike the first-generation adapter it adds per-input debounce, sticky button-press event capture with write-1-to-clear, an interrupt-enable mask and a registered interrupt output. It sits beside RAM and the terminal peripherals on the shared `addr`/`bwe`/`din`/`dout` bus.

---
 rtl/debug_io_pkg.sv | 17 +
 rtl/debug_io_if.sv | 9 +
 rtl/debounce_bit.sv | 31 +++
 rtl/debug_io_ctrl.sv | 75 +++++++
 tb/tb_debug_io_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/debug_io_pkg.sv
// debug_io_pkg: register offsets, ID constant and byte-lane helper for debug_io_ctrl
package debug_io_pkg;
    localparam logic [3:0] REG_LED  = 4'h0;
    localparam logic [3:0] REG_SSD  = 4'h2;
    localparam logic [3:0] REG_SW   = 4'h4;
    localparam logic [3:0] REG_BTN  = 4'h6;
    localparam logic [3:0] REG_EVT  = 4'h8;
    localparam logic [3:0] REG_IE   = 4'hA;
    localparam logic [3:0] REG_STAT = 4'hC;
    localparam logic [3:0] REG_ID   = 4'hE;
    localparam logic [15:0] DEBUG_IO_ID = 16'hD102;

    // expands the two byte enables into a 16-bit bit mask
    function automatic logic [15:0] lane_mask(input logic [1:0] bwe);
        return {{8{bwe[1]}}, {8{bwe[0]}}};
    endfunction
endpackage

// File: rtl/debug_io_if.sv
// debug_io_if: shared CPU data bus as seen by the debug I/O block
interface debug_io_if;
    logic [15:0] addr;
    logic [1:0]  bwe;
    logic [15:0] din;
    logic [15:0] dout;
    modport master (output addr, bwe, din, input dout);
    modport slave  (input addr, bwe, din, output dout);
endinterface

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchroniser, settle counter and rising-edge pulse for one pin
module debounce_bit #(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise
);
    localparam int CW = $clog2(DB_CYCLES);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          done;

    assign done = (sync[1] != q) && (cnt == CW'(DB_CYCLES - 1));
    assign rise = done && sync[1];

    // synchronise the pin, count consecutive disagreeing cycles, accept after the full period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            cnt  <= '0;
            q    <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            cnt  <= (sync[1] == q || done) ? '0 : cnt + 1'b1;
            if (done) q <= sync[1];
        end
    end
endmodule

// File: rtl/debug_io_ctrl.sv
// debug_io_ctrl: memory-mapped LEDs, display word, debounced inputs, press events and interrupt
module debug_io_ctrl
    import debug_io_pkg::*;
#(
    parameter int LED_W     = 8,
    parameter int SW_W      = 8,
    parameter int BTN_W     = 4,
    parameter int DB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    debug_io_if.slave        bus,
    input  logic [SW_W-1:0]  sw,
    input  logic [BTN_W-1:0] btn,
    output logic [LED_W-1:0] led,
    output logic [15:0]      ssd,
    output logic             irq
);
    localparam int NB = SW_W + BTN_W;
    logic [NB-1:0]    raw, q, rise;
    logic [BTN_W-1:0] evt, ie, clr;
    logic [15:0]      wm, rdata;
    logic [2:0]       sel;
    logic             unused_ok;

    assign raw       = {btn, sw};
    assign sel       = bus.addr[3:1];
    assign wm        = lane_mask(bus.bwe);
    assign clr       = (sel == REG_EVT[3:1]) ? bus.din[BTN_W-1:0] & wm[BTN_W-1:0] : '0;
    assign unused_ok = ^{bus.addr[15:4], bus.addr[0], rise[SW_W-1:0]};

    for (genvar i = 0; i < NB; i++) begin : g_db
        debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk (clk),
            .rst (rst),
            .din (raw[i]),
            .q   (q[i]),
            .rise(rise[i])
        );
    end

    // read mux on the word offset; narrow registers are zero-extended
    always_comb begin
        rdata = DEBUG_IO_ID;
        case (sel)
            REG_LED[3:1]:  rdata = 16'(led);
            REG_SSD[3:1]:  rdata = ssd;
            REG_SW[3:1]:   rdata = 16'(q[SW_W-1:0]);
            REG_BTN[3:1]:  rdata = 16'(q[NB-1:SW_W]);
            REG_EVT[3:1]:  rdata = 16'(evt);
            REG_IE[3:1]:   rdata = 16'(ie);
            REG_STAT[3:1]: rdata = {15'd0, irq};
            default:       rdata = DEBUG_IO_ID;
        endcase
    end

    // lane-masked writes, sticky events where a new press beats a same-cycle clear, registered irq and read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led      <= '0;
            ssd      <= '0;
            evt      <= '0;
            ie       <= '0;
            irq      <= 1'b0;
            bus.dout <= '0;
        end else begin
            if (sel == REG_LED[3:1]) led <= (led & ~wm[LED_W-1:0]) | (bus.din[LED_W-1:0] & wm[LED_W-1:0]);
            if (sel == REG_SSD[3:1]) ssd <= (ssd & ~wm) | (bus.din & wm);
            if (sel == REG_IE[3:1])  ie  <= (ie & ~wm[BTN_W-1:0]) | (bus.din[BTN_W-1:0] & wm[BTN_W-1:0]);
            evt      <= (evt & ~clr) | rise[NB-1:SW_W];
            irq      <= |(evt & ie);
            bus.dout <= rdata;
        end
    end
endmodule

// File: tb/tb_debug_io_ctrl.sv
// tb_debug_io_ctrl: directed and random stimulus against a pin-history reference model
module tb_debug_io_ctrl;
    localparam int LW = 8, SW = 8, BW = 4, DB = 4, NB = SW + BW;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] sw;
    logic [BW-1:0] btn;
    logic [LW-1:0] led;
    logic [15:0]   ssd;
    logic          irq;

    debug_io_if bus();

    debug_io_ctrl #(.LED_W(LW), .SW_W(SW), .BTN_W(BW), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sw(sw), .btn(btn), .led(led), .ssd(ssd), .irq(irq)
    );

    always #5 clk = ~clk;

    logic [LW-1:0] m_led;
    logic [15:0]   m_ssd, m_dout;
    logic [BW-1:0] m_evt, m_ie;
    logic          m_irq;
    logic [NB-1:0] m_q;
    logic [NB-1:0] hist[$];
    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [3:0] a);
        case (a[3:1])
            3'd0: return 16'(m_led);
            3'd1: return m_ssd;
            3'd2: return 16'(m_q[SW-1:0]);
            3'd3: return 16'(m_q[NB-1:SW]);
            3'd4: return 16'(m_evt);
            3'd5: return 16'(m_ie);
            3'd6: return {15'd0, m_irq};
            default: return 16'hD102;
        endcase
    endfunction

    task automatic m_reset();
        m_led = '0; m_ssd = '0; m_dout = '0; m_evt = '0; m_ie = '0; m_irq = 1'b0; m_q = '0;
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_front('0);
    endtask

    // one clock: the model sees the pins and bus as presented, then outputs are compared after the edge
    task automatic tick();
        logic [15:0] m, rd;
        logic [NB-1:0] nq;
        logic [BW-1:0] rise, clr;
        logic [3:0] a;
        logic irq_n;
        int diff;
        a = bus.addr[3:0];
        m = {{8{bus.bwe[1]}}, {8{bus.bwe[0]}}};
        rd = m_read(a);
        hist.push_front({btn, sw});
        void'(hist.pop_back());
        nq = m_q;
        for (int b = 0; b < NB; b++) begin
            diff = 0;
            for (int k = 2; k < DB + 2; k++) diff += (hist[k][b] != m_q[b]) ? 1 : 0;
            if (diff == DB) nq[b] = ~m_q[b];
        end
        rise = nq[NB-1:SW] & ~m_q[NB-1:SW];
        clr = (a[3:1] == 3'd4) ? BW'(bus.din & m) : '0;
        irq_n = |(m_evt & m_ie);
        m_evt = (m_evt & ~clr) | rise;
        if (a[3:1] == 3'd0) m_led = (m_led & ~LW'(m)) | LW'(bus.din & m);
        if (a[3:1] == 3'd1) m_ssd = (m_ssd & ~m) | (bus.din & m);
        if (a[3:1] == 3'd5) m_ie = (m_ie & ~BW'(m)) | BW'(bus.din & m);
        m_q = nq;
        m_dout = rd;
        m_irq = irq_n;
        @(posedge clk);
        #1;
        chk("dout", bus.dout, m_dout);
        chk("led", 16'(led), 16'(m_led));
        chk("ssd", ssd, m_ssd);
        chk("irq", 16'(irq), 16'(m_irq));
    endtask

    task automatic wr(input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
        bus.addr = a; bus.bwe = be; bus.din = d;
        tick();
        bus.bwe = 2'b00;
    endtask

    task automatic rd(input logic [15:0] a);
        bus.addr = a; bus.bwe = 2'b00;
        tick();
    endtask

    initial begin
        rst = 1'b1; sw = '0; btn = '0;
        bus.addr = '0; bus.bwe = 2'b00; bus.din = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", bus.dout, 16'h0000);
        chk("rst_led", 16'(led), 16'h0000);
        chk("rst_ssd", ssd, 16'h0000);
        chk("rst_irq", 16'(irq), 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rd(16'(2 * i));
            chk("reset_read", bus.dout, (i == 7) ? 16'hD102 : 16'h0000);
        end

        wr(16'h0000, 2'b01, 16'hABCD);
        chk("led_lo", 16'(led), 16'h00CD);
        wr(16'h0002, 2'b10, 16'h1234);
        chk("ssd_hi", ssd, 16'h1200);
        rd(16'h0002);
        chk("ssd_read", bus.dout, 16'h1200);

        btn[0] = 1'b1;
        repeat (3) tick();
        btn[0] = 1'b0;
        repeat (6) tick();
        rd(16'h0006);
        chk("glitch_btn", bus.dout, 16'h0000);
        rd(16'h0008);
        chk("glitch_evt", bus.dout, 16'h0000);

        wr(16'h000A, 2'b01, 16'h0001);
        btn[0] = 1'b1;
        bus.addr = 16'h0008;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("evt_latency", bus.dout, (k == 7) ? 16'h0001 : 16'h0000);
            chk("irq_latency", 16'(irq), (k == 7) ? 16'h0001 : 16'h0000);
        end
        rd(16'h0006);
        chk("btn_held", bus.dout, 16'h0001);

        wr(16'h0008, 2'b01, 16'h0001);
        chk("irq_before_clear", 16'(irq), 16'h0001);
        tick();
        chk("irq_after_clear", 16'(irq), 16'h0000);
        rd(16'h0008);
        chk("evt_cleared", bus.dout, 16'h0000);

        btn[0] = 1'b0;
        repeat (8) tick();
        btn[0] = 1'b1;
        repeat (8) tick();
        wr(16'h0008, 2'b01, 16'h0000);
        rd(16'h0008);
        chk("w0_keeps", bus.dout, 16'h0001);
        wr(16'h0008, 2'b11, 16'hFFFF);

        btn[1] = 1'b1;
        bus.addr = 16'h0000;
        repeat (5) tick();
        wr(16'h0008, 2'b01, 16'h0002);
        rd(16'h0008);
        chk("set_wins", bus.dout, 16'h0002);

        sw = 8'h5A;
        repeat (6) tick();
        rd(16'h0004);
        chk("sw_read", bus.dout, 16'h005A);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) sw = SW'($urandom);
            if ($urandom_range(7) == 0) btn = BW'($urandom);
            bus.addr = 16'($urandom);
            bus.din = 16'($urandom);
            bus.bwe = ($urandom_range(2) == 0) ? 2'($urandom) : 2'b00;
            tick();
        end
        bus.bwe = 2'b00;

        wr(16'h0000, 2'b11, 16'hFFFF);
        wr(16'h0002, 2'b11, 16'hBEEF);
        wr(16'h000A, 2'b11, 16'h000F);
        btn = 4'b1000;
        sw = ~sw;
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        chk("async_led", 16'(led), 16'h0000);
        chk("async_ssd", ssd, 16'h0000);
        chk("async_dout", bus.dout, 16'h0000);
        chk("async_irq", 16'(irq), 16'h0000);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.addr = 16'h0008;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("held_thru_rst", bus.dout, (k == 7) ? 16'h0008 : 16'h0000);
        end
        rd(16'h0004);
        rd(16'h000C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
